dram0_initiator: RTL and testbench

Initiator for the DRAM0 local-memory port (peregrine DRAM0, 64K x 32-bit, byte address window 0x00400000-0x0043FFFF, one-cycle read latency).
- Accepts byte-addressed word read/write requests on a valid/ready interface and drives the DRAM0 Addr/En/Wr/ByteEn/WrData pins.
- Captures DRam0Data0 one cycle after each access.
- Returns in-order responses on a valid/ready interface.
- Used by the cosim bench and the preload/DMA path to reach DRAM0 without the core.

---
 rtl/dram0_initiator.sv | 141 ++++++++++++++
 tb/tb_dram0_initiator.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram0_initiator.sv
// dram0_initiator: valid/ready initiator for the DRAM0 local-memory port.
// Two-stage pin pipeline feeding an in-order, credit-protected response FIFO.
module dram0_initiator #(
    parameter logic [31:0] MEM_BASE  = 32'h00400000,
    parameter int          AWIDTH    = 16,
    parameter int          RSP_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [3:0]        req_byteen,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic              rsp_error,
    output logic [31:0]       rsp_rdata,
    output logic [AWIDTH-1:0] DRam0Addr0,
    output logic              DRam0En0,
    output logic              DRam0Wr0,
    output logic [3:0]        DRam0ByteEn0,
    output logic [31:0]       DRam0WrData0,
    input  logic [31:0]       DRam0Data0
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [32:0] LO = {1'b0, MEM_BASE};
    localparam logic [32:0] HI = LO + (33'd4 << AWIDTH);

    logic              fire, pop, err, push;
    logic [AWIDTH-1:0] idx;
    logic              init_q;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              s1_vld_q, s1_vld_d, s1_err_q, s1_err_d, s1_wr_q, s1_wr_d;
    logic              s2_vld_q, s2_err_q, s2_wr_q;
    logic              en_q, en_d, wr_q, wr_d;
    logic [3:0]        be_q, be_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;

    logic [33:0]       mem_q [RSP_DEPTH];
    logic [33:0]       ent, head;
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     fcnt_q;

    // 33-bit compares keep the top window edge from wrapping
    assign err = (req_addr[1:0] != 2'b00)
              || ({1'b0, req_addr} < LO)
              || ({1'b0, req_addr} >= HI);
    assign idx = AWIDTH'((req_addr - MEM_BASE) >> 2);

    // credits cover S1, S2 and the FIFO, so a push always finds room
    assign req_ready = init_q && (cnt_q < CW'(RSP_DEPTH));
    assign fire      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign cnt_d     = cnt_q + CW'(fire) - CW'(pop);

    always_comb begin
        s1_vld_d = fire;
        s1_err_d = fire && err;
        s1_wr_d  = fire && req_write;
        en_d     = fire && !err;
        wr_d     = en_d && req_write;
        be_d     = wr_d ? req_byteen : 4'h0;
        addr_d   = addr_q;
        wd_d     = wd_q;
        if (en_d) begin
            addr_d = idx;
            wd_d   = req_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_q   <= 1'b0;
            cnt_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_err_q <= 1'b0;
            s1_wr_q  <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_err_q <= 1'b0;
            s2_wr_q  <= 1'b0;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= 4'h0;
            addr_q   <= '0;
            wd_q     <= '0;
        end else begin
            init_q   <= 1'b1;
            cnt_q    <= cnt_d;
            s1_vld_q <= s1_vld_d;
            s1_err_q <= s1_err_d;
            s1_wr_q  <= s1_wr_d;
            s2_vld_q <= s1_vld_q;
            s2_err_q <= s1_err_q;
            s2_wr_q  <= s1_wr_q;
            en_q     <= en_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
        end
    end

    assign DRam0En0     = en_q;
    assign DRam0Wr0     = wr_q;
    assign DRam0ByteEn0 = be_q;
    assign DRam0Addr0   = addr_q;
    assign DRam0WrData0 = wd_q;

    // memory data is only meaningful in S2 of a non-error read
    assign push = s2_vld_q;
    assign ent  = {s2_wr_q, s2_err_q,
                   (s2_wr_q || s2_err_q) ? 32'h0 : DRam0Data0};

    always_ff @(posedge CLK) begin
        if (push) mem_q[wp_q] <= ent;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
        end
    end

    assign head      = mem_q[rp_q];
    assign rsp_valid = (fcnt_q != '0);
    assign rsp_write = rsp_valid && head[33];
    assign rsp_error = rsp_valid && head[32];
    assign rsp_rdata = rsp_valid ? head[31:0] : 32'h0;
endmodule

// File: tb/tb_dram0_initiator.sv
// Bench for dram0_initiator: DRAM0 memory model, reference model of the
// request/response semantics, per-cycle compare and directed scenarios.
module tb_dram0_initiator;
    localparam logic [31:0] BASE = 32'h00400000;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_byteen;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [31:0] rsp_rdata;
    logic [15:0] DRam0Addr0;
    logic        DRam0En0, DRam0Wr0;
    logic [3:0]  DRam0ByteEn0;
    logic [31:0] DRam0WrData0, DRam0Data0;

    dram0_initiator dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_byteen(req_byteen), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_error(rsp_error),
        .rsp_rdata(rsp_rdata),
        .DRam0Addr0(DRam0Addr0), .DRam0En0(DRam0En0),
        .DRam0Wr0(DRam0Wr0), .DRam0ByteEn0(DRam0ByteEn0),
        .DRam0WrData0(DRam0WrData0), .DRam0Data0(DRam0Data0)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int vectors = 0;
    int errs = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] hash(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h3C6EF372;
    endfunction

    // DRAM0 memory: one-cycle read latency, byte-lane writes
    logic [31:0] dmem [65536];
    logic [31:0] mem_rd;
    logic        filled = 1'b0;
    logic        pre_en = 1'b0;
    logic [15:0] pre_idx = '0;
    logic [31:0] pre_val = '0;
    assign DRam0Data0 = mem_rd;

    always @(posedge CLK) begin
        if (!filled) begin
            for (int i = 0; i < 65536; i++) dmem[i] <= hash(i);
            filled <= 1'b1;
        end else if (pre_en) begin
            dmem[pre_idx] <= pre_val;
        end else if (DRam0En0 && DRam0Wr0) begin
            for (int b = 0; b < 4; b++)
                if (DRam0ByteEn0[b])
                    dmem[DRam0Addr0][b*8 +: 8] <= DRam0WrData0[b*8 +: 8];
        end
        if (DRam0En0 && !DRam0Wr0) mem_rd <= dmem[DRam0Addr0];
        else                       mem_rd <= $urandom;
    end

    // Reference model: sequential memory image plus in-order expectations
    typedef struct {
        logic        w;
        logic        e;
        logic [31:0] d;
        int          acc;
    } exp_t;

    logic [31:0] ref_mem [65536];
    exp_t        eq[$];
    int          outst = 0;
    int          since_rst = 0;
    logic        pend_en = 0, pend_wr = 0;
    logic [3:0]  pend_be = 0;
    logic [15:0] pend_addr = 0;
    logic [31:0] pend_wd = 0;
    logic        hold_q = 0, hold_w = 0, hold_e = 0;
    logic [31:0] hold_d = 0;
    logic [31:0] last_rdata = 0;
    int          last_lat = 0;
    int          pops_err = 0;
    int          en_cnt = 0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            eq.delete();
            outst = 0;
            since_rst = 0;
            pend_en = 0; pend_wr = 0; pend_be = 0;
            hold_q = 0;
        end else begin
            exp_t   x;
            longint a;
            int     ix;
            logic [31:0] m;
            since_rst++;
            check("pin_en", 32'(DRam0En0), 32'(pend_en));
            check("pin_wr", 32'(DRam0Wr0), 32'(pend_wr));
            check("pin_be", 32'(DRam0ByteEn0), 32'(pend_be));
            if (pend_en) begin
                en_cnt++;
                check("pin_addr", 32'(DRam0Addr0), 32'(pend_addr));
                check("pin_wdata", DRam0WrData0, pend_wd);
            end
            if (since_rst >= 2)
                check("req_ready", 32'(req_ready), 32'(outst < 4));
            if (hold_q) begin
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_data", {rsp_write, rsp_error, rsp_rdata[29:0]},
                      {hold_w, hold_e, hold_d[29:0]});
            end
            if (eq.size() == 0) begin
                check("rsp_idle", 32'(rsp_valid), 32'd0);
            end else if (rsp_valid) begin
                x = eq[0];
                check("rsp_write", 32'(rsp_write), 32'(x.w));
                check("rsp_error", 32'(rsp_error), 32'(x.e));
                check("rsp_rdata", rsp_rdata, x.d);
                check("rsp_latency_ge3", 32'(cyc - x.acc >= 3), 32'd1);
                if (rsp_ready) begin
                    last_rdata = rsp_rdata;
                    last_lat = cyc - x.acc;
                    if (rsp_error) pops_err++;
                    void'(eq.pop_front());
                    outst--;
                end
            end
            hold_q = rsp_valid && !rsp_ready;
            hold_w = rsp_write; hold_e = rsp_error; hold_d = rsp_rdata;

            pend_en = 0; pend_wr = 0; pend_be = 0;
            if (req_valid && req_ready) begin
                a = longint'(req_addr);
                x.w = req_write;
                x.acc = cyc;
                x.e = (a % 4 != 0) || (a < longint'(BASE))
                   || (a >= longint'(BASE) + 4 * 65536);
                x.d = 32'h0;
                if (!x.e) begin
                    ix = int'((a - longint'(BASE)) / 4);
                    pend_en = 1;
                    pend_addr = 16'(ix);
                    pend_wd = req_wdata;
                    if (req_write) begin
                        pend_wr = 1;
                        pend_be = req_byteen;
                        m = {{8{req_byteen[3]}}, {8{req_byteen[2]}},
                             {8{req_byteen[1]}}, {8{req_byteen[0]}}};
                        ref_mem[ix] = (ref_mem[ix] & ~m) | (req_wdata & m);
                    end else begin
                        x.d = ref_mem[ix];
                    end
                end
                eq.push_back(x);
                outst++;
                check("outstanding_le4", 32'(outst <= 4), 32'd1);
            end
        end
    end

    task automatic preload(input int ix, input logic [31:0] v);
        ref_mem[ix] = v;
        pre_idx = 16'(ix);
        pre_val = v;
        pre_en = 1'b1;
        @(posedge CLK); #1;
        pre_en = 1'b0;
    endtask

    task automatic send(input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a;
        req_byteen = be; req_wdata = d;
        do begin
            @(negedge CLK);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            vectors++;
            errs++;
            $display("FAIL send_timeout: got no accept expected accept for addr %h", a);
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_write = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (eq.size() != 0 && n < 500) begin
            @(posedge CLK); #1;
            n++;
        end
        check("drain", 32'(eq.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return BASE + ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
            1: return $urandom_range(0, 32'h003FFFFF) & ~32'h3;
            2: return 32'h00440000 + $urandom_range(0, 7) * 4;
            3: return 32'h0043FFFC;
            default: return BASE + $urandom_range(0, 15) * 4;
        endcase
    endfunction

    bit done;
    int k, e0, c0;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = hash(i);
        RST_N = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0;
        req_byteen = 0; req_wdata = 0; rsp_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_en", 32'(DRam0En0), 32'd0);
        check("rst_addr", 32'(DRam0Addr0), 32'd0);
        check("rst_wdata", DRam0WrData0, 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // single read: 3-cycle latency, one enable pulse at word 4
        preload(4, 32'hDEADBEEF);
        send(1'b0, 32'h00400010, 4'hF, $urandom);
        @(negedge CLK);
        check("t1_en_s1", 32'(DRam0En0), 32'd1);
        check("t1_addr", 32'(DRam0Addr0), 32'h4);
        @(negedge CLK);
        check("t1_en_s2", 32'(DRam0En0), 32'd0);
        @(negedge CLK);
        check("t1_valid", 32'(rsp_valid), 32'd1);
        check("t1_rdata", rsp_rdata, 32'hDEADBEEF);
        check("t1_err", 32'(rsp_error), 32'd0);
        check("t1_write", 32'(rsp_write), 32'd0);
        @(posedge CLK); #1;
        check("t1_lat", 32'(last_lat), 32'd3);

        // partial write followed immediately by a read of the same word
        preload(8, 32'h11223344);
        send(1'b1, 32'h00400020, 4'b0101, 32'hAABBCCDD);
        send(1'b0, 32'h00400020, 4'hF, $urandom);
        wait_drain();
        check("t2_raw", last_rdata, 32'h11BB33DD);

        // window edges and misalignment
        e0 = pops_err; c0 = en_cnt;
        send(1'b0, 32'h00400002, 4'hF, 0);
        send(1'b0, 32'h00440000, 4'hF, 0);
        send(1'b0, 32'h0043FFFC, 4'hF, 0);
        wait_drain();
        check("t3_errs", 32'(pops_err - e0), 32'd2);
        check("t3_enables", 32'(en_cnt - c0), 32'd1);

        // credit limit with consumer stalled
        rsp_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (k < 6);
            req_write = 1'b0;
            req_addr = BASE + 32'(k) * 4;
            @(negedge CLK);
            if (req_valid && req_ready) k++;
            @(posedge CLK); #1;
        end
        req_valid = 1'b0;
        check("t4_accepted", 32'(k), 32'd4);
        @(negedge CLK);
        check("t4_ready_low", 32'(req_ready), 32'd0);
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        @(negedge CLK);
        check("t4_head_valid", 32'(rsp_valid), 32'd1);
        @(negedge CLK);
        check("t4_ready_back", 32'(req_ready), 32'd1);
        wait_drain();

        // streaming reads under a 1/0 consumer
        done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send(1'b0, BASE + 32'($urandom_range(0, 31)) * 4, 4'hF, 0);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge CLK); #1;
                    rsp_ready = ~rsp_ready;
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain();

        // random mix with random gaps and random back-pressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send($urandom_range(0, 1), rand_addr(), 4'($urandom),
                         $urandom);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge CLK); #1;
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge CLK); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain();

        // reset with reads in flight
        rsp_ready = 1'b0;
        send(1'b0, BASE + 32'h40, 4'hF, 0);
        send(1'b0, BASE + 32'h44, 4'hF, 0);
        send(1'b0, BASE + 32'h48, 4'hF, 0);
        #2 RST_N = 1'b0;
        #1;
        check("t6_req_ready", 32'(req_ready), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_en", 32'(DRam0En0), 32'd0);
        check("t6_wr", 32'(DRam0Wr0), 32'd0);
        check("t6_be", 32'(DRam0ByteEn0), 32'd0);
        check("t6_addr", 32'(DRam0Addr0), 32'd0);
        check("t6_wdata", DRam0WrData0, 32'd0);
        check("t6_rsp", {rsp_write, rsp_error, rsp_rdata[29:0]}, 32'd0);
        repeat (2) @(posedge CLK); #1;
        RST_N = 1'b1;
        rsp_ready = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            check("t6_quiet", 32'(rsp_valid), 32'd0);
        end
        @(posedge CLK); #1;
        send(1'b0, BASE + 32'h4, 4'hF, 0);
        send(1'b1, BASE + 32'h4, 4'b1111, 32'hCAFEF00D);
        send(1'b0, BASE + 32'h4, 4'hF, 0);
        wait_drain();
        check("t6_after", last_rdata, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
